// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: field bundle + 32-bit immediate -> instruction word
// with a running byte address. Optional IMM_RANGE_CHECK_EN flags non-encodable immediates.
module instr_encoder #(
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              addr_clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err
);

   typedef enum logic [2:0] {
      FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
      FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
   } fmt_e;

   logic              r_s1_vld;
   fmt_e              r_s1_fmt;
   logic [6:0]        r_s1_op;
   logic [4:0]        r_s1_rd;
   logic [4:0]        r_s1_rs1;
   logic [4:0]        r_s1_rs2;
   logic [2:0]        r_s1_f3;
   logic [6:0]        r_s1_f7;
   logic [31:0]       r_s1_imm;

   logic              r_s2_vld;
   logic [31:0]       r_s2_instr;
   logic              r_s2_err;
   logic [ADDR_W-1:0] r_addr;

   logic              w_s2_en;
   logic              w_in_fire;
   logic              w_out_fire;
   logic [31:0]       w_pack;
   logic              w_fmt_err;
   logic              w_rng_err;

   assign w_s2_en    = !r_s2_vld || out_ready;
   assign in_ready   = !r_s1_vld || w_s2_en;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_s2_vld && out_ready;

   assign out_valid = r_s2_vld;
   assign out_instr = r_s2_instr;
   assign out_err   = r_s2_err;
   assign out_addr  = r_addr;

   // S1: capture the raw field bundle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld <= 1'b0;
         r_s1_fmt <= FMT_R;
         r_s1_op  <= '0;
         r_s1_rd  <= '0;
         r_s1_rs1 <= '0;
         r_s1_rs2 <= '0;
         r_s1_f3  <= '0;
         r_s1_f7  <= '0;
         r_s1_imm <= '0;
      end else begin
         if (in_ready) r_s1_vld <= in_valid;
         if (w_in_fire) begin
            r_s1_fmt <= fmt_e'(in_fmt);
            r_s1_op  <= in_opcode;
            r_s1_rd  <= in_rd;
            r_s1_rs1 <= in_rs1;
            r_s1_rs2 <= in_rs2;
            r_s1_f3  <= in_funct3;
            r_s1_f7  <= in_funct7;
            r_s1_imm <= in_imm;
         end
      end
   end

   always_comb begin
      w_pack    = 32'h0000_0013;
      w_fmt_err = 1'b0;
      case (r_s1_fmt)
         FMT_R: w_pack = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
         FMT_I: w_pack = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
         FMT_S: w_pack = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                          r_s1_imm[4:0], r_s1_op};
         FMT_B: w_pack = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                          r_s1_imm[4:1], r_s1_imm[11], r_s1_op};
         FMT_U: w_pack = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
         FMT_J: w_pack = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                          r_s1_imm[19:12], r_s1_rd, r_s1_op};
         default: begin
            w_pack    = 32'h0000_0013;
            w_fmt_err = 1'b1;
         end
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   // An immediate fits in N signed bits when bits [31:N-1] are all equal
   logic w_fit12, w_fit13, w_fit21;
   assign w_fit12 = (&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]);
   assign w_fit13 = (&r_s1_imm[31:12]) || !(|r_s1_imm[31:12]);
   assign w_fit21 = (&r_s1_imm[31:20]) || !(|r_s1_imm[31:20]);

   always_comb begin
      w_rng_err = 1'b0;
      case (r_s1_fmt)
         FMT_I, FMT_S: w_rng_err = !w_fit12;
         FMT_B:        w_rng_err = !w_fit13 || r_s1_imm[0];
         FMT_J:        w_rng_err = !w_fit21 || r_s1_imm[0];
         FMT_U:        w_rng_err = |r_s1_imm[11:0];
         default:      w_rng_err = 1'b0;
      endcase
   end
`else
   logic w_unused_imm0;
   assign w_unused_imm0 = r_s1_imm[0];
   assign w_rng_err     = 1'b0;
`endif

   // S2: output register, advances whenever the consumer is not stalling it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_vld   <= 1'b0;
         r_s2_instr <= '0;
         r_s2_err   <= 1'b0;
      end else if (w_s2_en) begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_instr <= w_pack;
            r_s2_err   <= w_fmt_err || w_rng_err;
         end
      end
   end

   // addr_clr takes priority over the per-transfer increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_addr <= BASE_ADDR;
      else if (addr_clr)   r_addr <= BASE_ADDR;
      else if (w_out_fire) r_addr <= r_addr + ADDR_W'(4);
   end

endmodule
